float_compare_reduce: RTL

Parametrised floating-point compare/select unit for the Versat accelerator datapath. It generalises the single-function greater-or-equal comparator to eight selectable operations, with correct signed-zero and NaN handling and a 2-stage pipeline. It also adds an optional streaming min/max reduction that returns the extreme value and its element index. It sits as a standard Versat functional unit: config-driven `op`/`length`, data on `in0`/`in1`, and a `start`/`done` handshake.

---
 rtl/float_cmp_pkg.sv | 29 ++
 rtl/float_compare_reduce_if.sv | 27 ++
 rtl/float_cmp_core.sv | 43 ++++
 rtl/float_compare_reduce.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/float_cmp_pkg.sv
// rtl/float_cmp_pkg.sv - op codes, FSM states and canonical qNaN helper for float_compare_reduce
package float_cmp_pkg;

   typedef enum logic [2:0] {
      OP_GT  = 3'd0,
      OP_GE  = 3'd1,
      OP_LT  = 3'd2,
      OP_LE  = 3'd3,
      OP_EQ  = 3'd4,
      OP_NE  = 3'd5,
      OP_MIN = 3'd6,
      OP_MAX = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // sign 0, exponent all-ones, mantissa MSB set; caller truncates to data_w
   function automatic logic [63:0] canon_qnan(input int data_w, input int exp_w);
      logic [63:0] r;
      r = ((64'd1 << exp_w) - 64'd1) << (data_w - exp_w - 1);
      r = r | (64'd1 << (data_w - exp_w - 2));
      return r;
   endfunction

endpackage

// File: rtl/float_compare_reduce_if.sv
// rtl/float_compare_reduce_if.sv - handshake, config and data bundle of float_compare_reduce
interface float_compare_reduce_if #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
);
   logic              running;
   logic              run;
   logic              start;
   logic              done;
   logic [2:0]        op;
   logic [LEN_W-1:0]  length;
   logic [DATA_W-1:0] in0;
   logic [DATA_W-1:0] in1;
   logic [DATA_W-1:0] out0;
   logic [DATA_W-1:0] out1;
   logic [DATA_W-1:0] out2;

   modport master (
      output running, run, start, op, length, in0, in1,
      input  done, out0, out1, out2
   );

   modport slave (
      input  running, run, start, op, length, in0, in1,
      output done, out0, out1, out2
   );
endinterface

// File: rtl/float_cmp_core.sv
// rtl/float_cmp_core.sv - combinational float classify and ordered less/equal compare of a against b
module float_cmp_core #(
   parameter int DATA_W = 32,
   parameter int EXP_W  = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              a_nan,
   output logic              b_nan,
   output logic              lt,
   output logic              eq
);
   localparam int MAN_W = DATA_W - EXP_W - 1;

   logic a_zero, b_zero, mag_lt, mag_eq, ordered;

   assign a_nan   = (&a[DATA_W-2 -: EXP_W]) && (|a[MAN_W-1:0]);
   assign b_nan   = (&b[DATA_W-2 -: EXP_W]) && (|b[MAN_W-1:0]);
   assign a_zero  = ~|a[DATA_W-2:0];
   assign b_zero  = ~|b[DATA_W-2:0];
   assign mag_lt  = a[DATA_W-2:0] < b[DATA_W-2:0];
   assign mag_eq  = a[DATA_W-2:0] == b[DATA_W-2:0];
   assign ordered = !(a_nan || b_nan);

   always_comb begin
      lt = 1'b0;
      eq = 1'b0;
      if (a_zero && b_zero) begin
         eq = 1'b1;
      end else if (a[DATA_W-1] != b[DATA_W-1]) begin
         lt = a[DATA_W-1];
      end else if (a[DATA_W-1]) begin
         // both negative: larger magnitude is the smaller value
         lt = !mag_lt && !mag_eq;
         eq = mag_eq;
      end else begin
         lt = mag_lt;
         eq = mag_eq;
      end
      lt = lt && ordered;
      eq = eq && ordered;
   end
endmodule

// File: rtl/float_compare_reduce.sv
// rtl/float_compare_reduce.sv - float compare/select pipeline with min/max reduction under FLOAT_CMP_REDUCE_EN
module float_compare_reduce
   import float_cmp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int EXP_W  = 8,
   parameter int LEN_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   float_compare_reduce_if.slave bus
);
   localparam logic [DATA_W-1:0] QNAN = DATA_W'(canon_qnan(DATA_W, EXP_W));

   logic              e_a_nan, e_b_nan, e_lt, e_eq;
   logic [DATA_W-1:0] s1_a, s1_b;
   op_e               s1_op;
   logic              s1_a_nan, s1_b_nan, s1_lt, s1_eq;
   logic [DATA_W-1:0] res, out0_q;
   logic              any_nan, gt;
   logic              start_d1, done_q;

   float_cmp_core #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_elem (
      .a     (bus.in0),
      .b     (bus.in1),
      .a_nan (e_a_nan),
      .b_nan (e_b_nan),
      .lt    (e_lt),
      .eq    (e_eq)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_GT;
         s1_a_nan <= 1'b0;
         s1_b_nan <= 1'b0;
         s1_lt    <= 1'b0;
         s1_eq    <= 1'b0;
         start_d1 <= 1'b0;
      end else begin
         s1_a     <= bus.in0;
         s1_b     <= bus.in1;
         s1_op    <= op_e'(bus.op);
         s1_a_nan <= e_a_nan;
         s1_b_nan <= e_b_nan;
         s1_lt    <= e_lt;
         s1_eq    <= e_eq;
         start_d1 <= bus.start;
      end
   end

   always_comb begin
      res     = '0;
      any_nan = s1_a_nan || s1_b_nan;
      gt      = !s1_lt && !s1_eq && !any_nan;
      case (s1_op)
         OP_GT: res = {DATA_W{gt}};
         OP_GE: res = {DATA_W{!s1_lt && !any_nan}};
         OP_LT: res = {DATA_W{s1_lt}};
         OP_LE: res = {DATA_W{s1_lt || s1_eq}};
         OP_EQ: res = {DATA_W{s1_eq}};
         OP_NE: res = {DATA_W{!s1_eq}};
         OP_MIN, OP_MAX: begin
            if (s1_a_nan && s1_b_nan)  res = QNAN;
            else if (s1_a_nan)         res = s1_b;
            else if (s1_b_nan)         res = s1_a;
            else if (s1_op == OP_MIN)  res = (s1_lt || s1_eq) ? s1_a : s1_b;
            else                       res = (gt || s1_eq) ? s1_a : s1_b;
         end
         default: res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) out0_q <= '0;
      else     out0_q <= res;
   end

   assign bus.out0 = out0_q;
   assign bus.done = done_q;

`ifdef FLOAT_CMP_REDUCE_EN
   state_e            state, state_nx;
   logic [LEN_W-1:0]  count, acc_idx;
   logic [DATA_W-1:0] acc, out1_q, out2_q;
   logic              acc_valid, red_en, restart, consume, latch;
   logic              s_nan, acc_nan, s_lt, s_eq, better, take;

   assign red_en = bus.length != '0;

   float_cmp_core #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_red (
      .a     (bus.in0),
      .b     (acc),
      .a_nan (s_nan),
      .b_nan (acc_nan),
      .lt    (s_lt),
      .eq    (s_eq)
   );

   // strict improvement only, so ties keep the earlier index
   assign better = (bus.op == OP_MAX) ? (!s_lt && !s_eq) : s_lt;
   assign take   = !s_nan && (!acc_valid || (better && !acc_nan));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (bus.run && red_en) begin
         state_nx = ST_ACC;
      end else begin
         case (state)
            ST_IDLE:  state_nx = ST_IDLE;
            ST_ACC:   if (bus.running && (count + LEN_W'(1) == bus.length)) state_nx = ST_DRAIN;
            ST_DRAIN: state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      restart = bus.run && red_en;
      consume = (state == ST_ACC) && bus.running && !restart;
      latch   = (state == ST_DRAIN) && !restart;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count     <= '0;
         acc       <= '0;
         acc_idx   <= '0;
         acc_valid <= 1'b0;
      end else if (restart) begin
         count     <= '0;
         acc       <= '0;
         acc_idx   <= '0;
         acc_valid <= 1'b0;
      end else if (consume) begin
         count <= count + LEN_W'(1);
         if (take) begin
            acc       <= bus.in0;
            acc_idx   <= count;
            acc_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out1_q <= '0;
         out2_q <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= red_en ? latch : start_d1;
         if (latch) begin
            if (bus.op != OP_MIN && bus.op != OP_MAX) begin
               out1_q <= '0;
               out2_q <= '0;
            end else if (acc_valid) begin
               out1_q <= acc;
               out2_q <= DATA_W'(acc_idx);
            end else begin
               out1_q <= QNAN;
               out2_q <= DATA_W'({LEN_W{1'b1}});
            end
         end
      end
   end

   assign bus.out1 = out1_q;
   assign bus.out2 = out2_q;
`else
   logic unused_cfg;
   assign unused_cfg = bus.run ^ (|bus.length);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) done_q <= 1'b0;
      else     done_q <= start_d1;
   end

   assign bus.out1 = '0;
   assign bus.out2 = '0;
`endif
endmodule
